serial_add_ctrl: RTL and testbench

- Sequencer for a bit-serial full-adder datapath: accepts two N-bit operands on a START handshake and streams them LSB-first through a 1-bit full adder with a carry flop.
- Collects sum bits into a result shift register and reports the N-bit result, carry-out and signed overflow with a DONE flag.
- Supports add and subtract (two's complement: B inverted, carry seeded to 1).
- Sits between a host/register interface and the serial arithmetic path, so the host can issue multi-bit additions.

---
 rtl/serial_add_ctrl.sv | 144 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequencer for a bit-serial add/subtract datapath.
// Streams two N-bit operands LSB-first through a 1-bit full adder and reports SUM/COUT/OVF with DONE.
`default_nettype none

module serial_add_ctrl #(
   parameter int N  = 8,
   parameter int CW = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic         SUB,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         CIN,
   output logic         BUSY,
   output logic         DONE,
   output logic [N-1:0] SUM,
   output logic         COUT,
   output logic         OVF,
   output logic         SBIT
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t        state_q, state_d;
   logic [N-1:0]  ra_q, ra_d;
   logic [N-1:0]  rb_q, rb_d;
   logic          c_q, c_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          amsb_q, amsb_d;
   logic          bmsb_q, bmsb_d;
   logic [N-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;
   logic          sbit_q, sbit_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          s_bit;
   logic          c_next;

   assign s_bit  = ra_q[0] ^ rb_q[0] ^ c_q;
   assign c_next = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         sbit_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         amsb_q  <= amsb_d;
         bmsb_q  <= bmsb_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         sbit_q  <= sbit_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      amsb_d  = amsb_q;
      bmsb_d  = bmsb_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      sbit_d  = sbit_q;
      busy_d  = busy_q;
      done_d  = done_q;

      case (state_q)
         S_IDLE, S_FIN: begin
            if (START) begin
               // Subtract is A + ~B + 1: invert B and seed the carry.
               ra_d    = A;
               rb_d    = SUB ? ~B : B;
               c_d     = SUB ? 1'b1 : CIN;
               cnt_d   = '0;
               amsb_d  = A[N-1];
               bmsb_d  = SUB ? ~B[N-1] : B[N-1];
               sum_d   = '0;
               done_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            ra_d   = ra_q >> 1;
            rb_d   = rb_q >> 1;
            c_d    = c_next;
            sum_d  = {s_bit, sum_q[N-1:1]};
            sbit_d = s_bit;
            cnt_d  = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               cout_d  = c_next;
               ovf_d   = (amsb_q == bmsb_q) && (s_bit != amsb_q);
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_FIN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign SUM  = sum_q;
   assign COUT = cout_q;
   assign OVF  = ovf_q;
   assign SBIT = sbit_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: random and directed stimulus for serial_add_ctrl, checked every cycle
// against an arithmetic reference model plus literal expectations.
`default_nettype none

module tb_serial_add_ctrl;
   localparam int N  = 8;
   localparam int CW = 4;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         START = 1'b0;
   logic         SUB = 1'b0;
   logic [N-1:0] A = '0;
   logic [N-1:0] B = '0;
   logic         CIN = 1'b0;
   logic         BUSY, DONE, COUT, OVF, SBIT;
   logic [N-1:0] SUM;

   int n_cmp = 0;
   int n_bad = 0;

   serial_add_ctrl #(.N(N), .CW(CW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .A(A), .B(B), .CIN(CIN),
      .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT), .OVF(OVF), .SBIT(SBIT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an operation is a count of busy cycles followed by a
   // held result computed with plain N+1-bit arithmetic.
   int           m_left = 0;
   logic         m_done = 1'b0;
   logic [N-1:0] m_sum = '0, p_sum = '0;
   logic         m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;

   always @(posedge CLK or posedge RST) begin
      logic [N:0]   full;
      logic [N-1:0] beff;
      if (RST) begin
         m_left = 0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_done = 1'b1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
         end
      end else if (START) begin
         beff   = SUB ? ~B : B;
         full   = {1'b0, A} + {1'b0, beff} + ((SUB ? 1'b1 : CIN) ? 9'd1 : 9'd0);
         p_sum  = full[N-1:0];
         p_cout = full[N];
         p_ovf  = (A[N-1] == beff[N-1]) && (p_sum[N-1] != A[N-1]);
         m_left = N;
         m_done = 1'b0;
      end
   end

   always @(negedge CLK) begin
      if (!RST) begin
         chk("busy", 32'(BUSY), 32'(m_left > 0));
         chk("done", 32'(DONE), 32'(m_done));
         if (m_done) begin
            chk("sum", 32'(SUM), 32'(m_sum));
            chk("cout", 32'(COUT), 32'(m_cout));
            chk("ovf", 32'(OVF), 32'(m_ovf));
            chk("sbit", 32'(SBIT), 32'(m_sum[N-1]));
         end else if (m_left == 0) begin
            chk("idle_sum", 32'(SUM), 32'h0);
            chk("idle_cout", 32'(COUT), 32'h0);
            chk("idle_ovf", 32'(OVF), 32'h0);
            chk("idle_sbit", 32'(SBIT), 32'h0);
         end
      end
   end

   // Drives a one-cycle START from the current (non-edge) time, then scrambles inputs.
   task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin, input logic sub);
      A = a; B = b; CIN = cin; SUB = sub; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      A = N'($urandom); B = N'($urandom); CIN = 1'($urandom); SUB = 1'($urandom);
   endtask

   task automatic wait_done(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CLK);
         if (DONE) seen = 1'b1;
      end
      if (!seen) chk({nm, "_timeout"}, 32'h0, 32'h1);
   endtask

   task automatic directed(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic cin, input logic sub,
                           input logic [N-1:0] es, input logic ec, input logic eo);
      @(posedge CLK); #1;
      launch(a, b, cin, sub);
      wait_done(nm);
      chk({nm, "_sum"}, 32'(SUM), 32'(es));
      chk({nm, "_cout"}, 32'(COUT), 32'(ec));
      chk({nm, "_ovf"}, 32'(OVF), 32'(eo));
   endtask

   initial begin
      #12 RST = 1'b0;
      repeat (5) @(negedge CLK);
      chk("rst_sum", 32'(SUM), 32'h0);
      chk("rst_done", 32'(DONE), 32'h0);

      directed("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
      repeat (3) @(negedge CLK);
      chk("hold_done", 32'(DONE), 32'h1);
      directed("ripple", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      directed("cin", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
      directed("sub57", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
      directed("sub80", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

      // START during RUN must be ignored.
      @(posedge CLK); #1;
      launch(8'h01, 8'h01, 1'b0, 1'b0);
      @(posedge CLK); @(posedge CLK); #1;
      A = 8'h11; B = 8'h22; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      wait_done("ignore");
      chk("ignore_sum", 32'(SUM), 32'h02);

      // Relaunch on the cycle DONE is high.
      launch(8'h10, 8'h20, 1'b0, 1'b0);
      @(negedge CLK);
      chk("relaunch_done_low", 32'(DONE), 32'h0);
      wait_done("relaunch");
      chk("relaunch_sum", 32'(SUM), 32'h30);

      // Asynchronous reset mid-operation.
      @(posedge CLK); #1;
      launch(8'hAA, 8'h55, 1'b0, 1'b0);
      @(posedge CLK); @(posedge CLK); @(posedge CLK); #2;
      RST = 1'b1;
      #1;
      chk("arst_busy", 32'(BUSY), 32'h0);
      chk("arst_sum", 32'(SUM), 32'h0);
      chk("arst_done", 32'(DONE), 32'h0);
      @(posedge CLK); @(posedge CLK); #3;
      RST = 1'b0;
      repeat (12) @(negedge CLK);
      chk("arst_no_done", 32'(DONE), 32'h0);
      directed("after_rst", 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

      for (int k = 0; k < 60; k++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(posedge CLK);
         @(posedge CLK); #1;
         launch(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
         wait_done("rand");
      end

      repeat (2) @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
